// File: rtl/hazard_bypass_unit.sv
// Hazard/bypass unit: tracks X/M/W destinations, selects bypassed operands for
// decode, raises a one-cycle load-use stall and counts stall cycles (saturating).
module hazard_bypass_unit #(
    parameter int DATA_W      = 32,
    parameter int REG_W       = 5,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   id_valid_i,
    input  logic [REG_W-1:0]       id_rs_i,
    input  logic [REG_W-1:0]       id_rt_i,
    input  logic                   id_uses_a_i,
    input  logic                   id_uses_b_i,
    input  logic                   id_wen_i,
    input  logic [REG_W-1:0]       id_wd_i,
    input  logic                   id_is_load_i,
    input  logic                   flush_i,
    input  logic [DATA_W-1:0]      rf_a_i,
    input  logic [DATA_W-1:0]      rf_b_i,
    input  logic [DATA_W-1:0]      ex_result_i,
    input  logic [DATA_W-1:0]      mem_result_i,
    input  logic [DATA_W-1:0]      wb_result_i,
    output logic [DATA_W-1:0]      op_a_o,
    output logic [DATA_W-1:0]      op_b_o,
    output logic [1:0]             fwd_a_sel_o,
    output logic [1:0]             fwd_b_sel_o,
    output logic                   stall_o,
    output logic [STALL_CNT_W-1:0] stall_cnt_o
);
    typedef struct packed {
        logic             valid;
        logic             wen;
        logic [REG_W-1:0] wd;
    } prod_t;

    localparam logic [1:0] SEL_RF = 2'd0;
    localparam logic [1:0] SEL_X  = 2'd1;
    localparam logic [1:0] SEL_M  = 2'd2;
    localparam logic [1:0] SEL_W  = 2'd3;

    // The load flag only matters while the load sits in X, so M/W drop it.
    prod_t x_q, x_d, m_q, w_q;
    logic  x_load_q, x_load_d;
    logic [STALL_CNT_W-1:0] cnt_q, cnt_d;
    logic  haz_a, haz_b;

    function automatic logic is_prod(prod_t s, logic [REG_W-1:0] r);
        return s.valid & s.wen & (s.wd == r) & (r != '0);
    endfunction

    function automatic logic [1:0] fwd_sel(logic uses, logic [REG_W-1:0] r,
                                           prod_t sx, prod_t sm, prod_t sw);
        if (!uses)             return SEL_RF;
        else if (is_prod(sx, r)) return SEL_X;
        else if (is_prod(sm, r)) return SEL_M;
        else if (is_prod(sw, r)) return SEL_W;
        else                   return SEL_RF;
    endfunction

    always_comb begin
        fwd_a_sel_o = fwd_sel(id_uses_a_i, id_rs_i, x_q, m_q, w_q);
        fwd_b_sel_o = fwd_sel(id_uses_b_i, id_rt_i, x_q, m_q, w_q);

        haz_a   = id_uses_a_i & is_prod(x_q, id_rs_i) & x_load_q;
        haz_b   = id_uses_b_i & is_prod(x_q, id_rt_i) & x_load_q;
        stall_o = id_valid_i & (haz_a | haz_b) & ~flush_i;

        case (fwd_a_sel_o)
            SEL_X:   op_a_o = ex_result_i;
            SEL_M:   op_a_o = mem_result_i;
            SEL_W:   op_a_o = wb_result_i;
            default: op_a_o = rf_a_i;
        endcase
        case (fwd_b_sel_o)
            SEL_X:   op_b_o = ex_result_i;
            SEL_M:   op_b_o = mem_result_i;
            SEL_W:   op_b_o = wb_result_i;
            default: op_b_o = rf_b_i;
        endcase
    end

    always_comb begin
        x_d      = '0;
        x_load_d = 1'b0;
        if (id_valid_i && !stall_o && !flush_i) begin
            x_d.valid = 1'b1;
            x_d.wen   = id_wen_i;
            x_d.wd    = id_wd_i;
            x_load_d  = id_is_load_i;
        end
        cnt_d = cnt_q;
        if (stall_o && (cnt_q != '1))
            cnt_d = cnt_q + STALL_CNT_W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            x_q      <= '0;
            x_load_q <= 1'b0;
            m_q      <= '0;
            w_q      <= '0;
            cnt_q    <= '0;
        end else begin
            x_q      <= x_d;
            x_load_q <= x_load_d;
            m_q      <= x_q;
            w_q      <= m_q;
            cnt_q    <= cnt_d;
        end
    end

    assign stall_cnt_o = cnt_q;
endmodule

// File: tb/tb_hazard_bypass_unit.sv
// Directed bench for hazard_bypass_unit; expected responses are queued when a
// step is driven and popped when the combinational outputs are sampled.
module tb_hazard_bypass_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_valid = 1'b0, id_uses_a = 1'b0, id_uses_b = 1'b0;
    logic        id_wen = 1'b0, id_is_load = 1'b0, flush = 1'b0;
    logic [4:0]  id_rs = '0, id_rt = '0, id_wd = '0;
    logic [31:0] rf_a = 32'h11, rf_b = 32'h22;
    logic [31:0] ex_res = 32'hFFFF_FFFF, mem_res = 32'hFFFF_FFFF, wb_res = 32'hFFFF_FFFF;
    logic [31:0] op_a, op_b, op_a4, op_b4;
    logic [1:0]  sel_a, sel_b, sel_a4, sel_b4;
    logic        stall, stall4;
    logic [15:0] cnt;
    logic [3:0]  cnt4;

    int checks = 0;
    int failures = 0;
    int ecnt = 0;

    typedef struct {
        string       tag;
        logic [1:0]  sa, sb;
        logic [31:0] oa, ob;
        logic        st;
        logic [15:0] c;
        logic [3:0]  c4;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    hazard_bypass_unit #(.DATA_W(32), .REG_W(5), .STALL_CNT_W(16)) dut (
        .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_rs_i(id_rs), .id_rt_i(id_rt),
        .id_uses_a_i(id_uses_a), .id_uses_b_i(id_uses_b), .id_wen_i(id_wen), .id_wd_i(id_wd),
        .id_is_load_i(id_is_load), .flush_i(flush), .rf_a_i(rf_a), .rf_b_i(rf_b),
        .ex_result_i(ex_res), .mem_result_i(mem_res), .wb_result_i(wb_res),
        .op_a_o(op_a), .op_b_o(op_b), .fwd_a_sel_o(sel_a), .fwd_b_sel_o(sel_b),
        .stall_o(stall), .stall_cnt_o(cnt));

    hazard_bypass_unit #(.DATA_W(32), .REG_W(5), .STALL_CNT_W(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_rs_i(id_rs), .id_rt_i(id_rt),
        .id_uses_a_i(id_uses_a), .id_uses_b_i(id_uses_b), .id_wen_i(id_wen), .id_wd_i(id_wd),
        .id_is_load_i(id_is_load), .flush_i(flush), .rf_a_i(rf_a), .rf_b_i(rf_b),
        .ex_result_i(ex_res), .mem_result_i(mem_res), .wb_result_i(wb_res),
        .op_a_o(op_a4), .op_b_o(op_b4), .fwd_a_sel_o(sel_a4), .fwd_b_sel_o(sel_b4),
        .stall_o(stall4), .stall_cnt_o(cnt4));

    task automatic chk(string tag, string fld, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, fld, obs, exp);
        end
    endtask

    task automatic id(logic v, logic [4:0] rs, logic [4:0] rt, logic ua, logic ub,
                      logic wen, logic [4:0] wd, logic ld);
        id_valid = v; id_rs = rs; id_rt = rt; id_uses_a = ua; id_uses_b = ub;
        id_wen = wen; id_wd = wd; id_is_load = ld;
    endtask

    // Called at posedge+1 with id_* already set; samples at posedge+4.
    task automatic step(string tag, logic fl, logic r, logic [1:0] esa, logic [1:0] esb,
                        logic [31:0] eoa, logic [31:0] eob, logic est);
        exp_t e;
        flush = fl;
        rst   = r;
        e.tag = tag; e.sa = esa; e.sb = esb; e.oa = eoa; e.ob = eob; e.st = est;
        e.c   = 16'(ecnt);
        e.c4  = (ecnt > 15) ? 4'hF : 4'(ecnt);
        q.push_back(e);
        #3;
        checks++;
        if (q.size() == 0) begin
            failures++;
            $error("FAIL %s.queue observed=empty expected=entry", tag);
        end else begin
            e = q.pop_front();
            chk(e.tag, "sel_a", 32'(sel_a), 32'(e.sa));
            chk(e.tag, "sel_b", 32'(sel_b), 32'(e.sb));
            chk(e.tag, "op_a", op_a, e.oa);
            chk(e.tag, "op_b", op_b, e.ob);
            chk(e.tag, "stall", 32'(stall), 32'(e.st));
            chk(e.tag, "cnt", 32'(cnt), 32'(e.c));
            chk(e.tag, "cnt4", 32'(cnt4), 32'(e.c4));
        end
        if (r) ecnt = 0;
        else if (est) ecnt++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        id(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        step("reset", 0, 0, 0, 0, 32'h11, 32'h22, 0);
        ex_res = 32'hE0E0; mem_res = 32'hA0A0; wb_res = 32'hB0B0;

        // ALU chain: add r3, then readers at distance 1, 2 and 3
        id(1, 1, 2, 1, 1, 1, 3, 0);  step("add_r3", 0, 0, 0, 0, 32'h11, 32'h22, 0);
        ex_res = 32'h1234;
        id(1, 3, 2, 1, 1, 0, 0, 0);  step("alu_x", 0, 0, 1, 0, 32'h1234, 32'h22, 0);
        ex_res = 32'hE0E0;
        id(1, 0, 3, 0, 1, 0, 0, 0);  step("alu_m", 0, 0, 0, 2, 32'h11, 32'hA0A0, 0);
        wb_res = 32'h1234;
        id(1, 3, 0, 1, 0, 0, 0, 0);  step("alu_w", 0, 0, 3, 0, 32'h1234, 32'h22, 0);
        wb_res = 32'hB0B0;

        // Load-use: lw r5, dependent on rt stalls once, then takes M
        id(1, 0, 0, 0, 0, 1, 5, 1);  step("lw_r5", 0, 0, 0, 0, 32'h11, 32'h22, 0);
        id(1, 1, 5, 1, 1, 1, 7, 0);  step("lu_stall", 0, 0, 0, 1, 32'h11, 32'hE0E0, 1);
        step("lu_after", 0, 0, 0, 2, 32'h11, 32'hA0A0, 0);

        // r0 never forwards or stalls; W still forwards lw r5
        id(1, 0, 5, 1, 1, 1, 0, 1);  step("r0_w5", 0, 0, 0, 3, 32'h11, 32'hB0B0, 0);
        id(1, 0, 0, 1, 1, 1, 0, 0);  step("r0_xld", 0, 0, 0, 0, 32'h11, 32'h22, 0);
        step("r0_xm", 0, 0, 0, 0, 32'h11, 32'h22, 0);
        id(1, 0, 0, 1, 1, 1, 4, 0);  step("r0_xmw", 0, 0, 0, 0, 32'h11, 32'h22, 0);
        id(1, 0, 0, 0, 0, 1, 4, 0);  step("r4_wr2", 0, 0, 0, 0, 32'h11, 32'h22, 0);
        id(1, 4, 4, 1, 0, 0, 0, 0);  step("r4_prio", 0, 0, 1, 0, 32'hE0E0, 32'h22, 0);

        // Flush beats a pending load-use hazard
        id(1, 0, 0, 0, 0, 1, 6, 1);  step("lw_r6", 0, 0, 0, 0, 32'h11, 32'h22, 0);
        id(1, 6, 4, 1, 0, 0, 0, 0);  step("flush", 1, 0, 1, 0, 32'hE0E0, 32'h22, 0);
        id(1, 6, 4, 1, 1, 0, 0, 0);  step("post_flush", 0, 0, 2, 0, 32'hA0A0, 32'h22, 0);

        // Reset asserted while stalling
        id(1, 0, 0, 0, 0, 1, 8, 1);  step("lw_r8", 0, 0, 0, 0, 32'h11, 32'h22, 0);
        id(1, 8, 0, 1, 0, 0, 0, 0);  step("rst_stall", 0, 1, 1, 0, 32'hE0E0, 32'h22, 1);
        step("after_rst", 0, 0, 0, 0, 32'h11, 32'h22, 0);

        // Self-dependent lw r5 each cycle: stalls every other cycle, 20 stalls
        id(1, 5, 0, 1, 0, 1, 5, 1);
        for (int k = 0; k < 40; k++) begin
            if (k == 0)          step("sat", 0, 0, 0, 0, 32'h11, 32'h22, 0);
            else if (k % 2 == 1) step("sat", 0, 0, 1, 0, 32'hE0E0, 32'h22, 1);
            else                 step("sat", 0, 0, 2, 0, 32'hA0A0, 32'h22, 0);
        end
        chk("sat_end", "cnt4", 32'(cnt4), 32'hF);
        chk("sat_end", "cnt", 32'(cnt), 32'd20);

        id(0, 0, 0, 0, 0, 0, 0, 0);
        step("sat_rst", 0, 1, 0, 0, 32'h11, 32'h22, 0);
        step("cleared", 0, 0, 0, 0, 32'h11, 32'h22, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
